mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RAM_AW, default 12: RAM word-address width.
REQ-002 Parameter STARVE_MAX, default 4: fixed-priority mode only; consecutive IF denials before IF is forced to win.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req_valid  input  1  instruction-fetch read request.
REQ-006 if_req_ready  output  1  IF request accepted this cycle.
REQ-007 if_req_addr  input  32  IF byte address.
REQ-008 if_rsp_valid  output  1  IF read data valid.
REQ-009 if_rsp_data  output  32  IF read data.
REQ-010 d_req_valid  input  1  load/store request.
REQ-011 d_req_ready  output  1  data request accepted this cycle.
REQ-012 d_req_addr  input  32  data byte address.
REQ-013 d_req_we  input  1  1 = store, 0 = load.
REQ-014 d_req_wstrb  input  4  store byte enables.
REQ-015 d_req_wdata  input  32  store data.
REQ-016 d_rsp_valid  output  1  load data valid, or store acknowledge.
REQ-017 d_rsp_data  output  32  load data; 0 for a store acknowledge.
REQ-018 ram_en  output  1  RAM access strobe.
REQ-019 ram_we  output  4  RAM byte write enables.
REQ-020 ram_addr  output  RAM_AW  RAM word address.
REQ-021 ram_wdata  output  32  RAM write data.
REQ-022 ram_rdata  input  32  RAM read data, valid one cycle after ram_en.

Function
REQ-023 The block SHALL drive the single RAM port from at most one requester per cycle; ready is combinational from valid and arbitration state; a handshake is valid && ready.
REQ-024 In any cycle, the winner SHALL see ready=1; the loser SHALL see ready=0; with no valid request, ram_en=0 and both readies are 0.
REQ-025 ram_en SHALL be 1 in the handshake cycle; ram_addr = req_addr[RAM_AW+1:2], and address bits [1:0] SHALL be ignored.
REQ-026 ram_we SHALL be d_req_wstrb for an accepted store and 4'b0000 otherwise; a store with wstrb=0 SHALL still be acknowledged.
REQ-027 The response SHALL appear exactly 1 cycle after the handshake on the owner's rsp channel only, for exactly one cycle, with no backpressure.
REQ-028 A response-owner register SHALL record the accepted requester: IF, D-load, D-store, or none.
REQ-029 Throughput SHALL be one access per cycle; a new grant in the same cycle as a pending response is legal.
REQ-030 Fixed-priority mode: data SHALL win ties; an 3-bit starve counter SHALL increment on each cycle where IF is valid and not granted.
REQ-031 Fixed-priority mode: the starve counter SHALL clear on an IF grant or when if_req_valid=0; at count == STARVE_MAX, IF SHALL win the next tie.

Reset
REQ-032 While rst=1 at a clock edge: both rsp_valid=0, rsp_data=0, response owner=none, starve counter=0, and the round-robin pointer SHALL favour IF.
REQ-033 While rst=1, ready and ram_en SHALL be 0; a response for an access accepted in the cycle before reset SHALL be dropped.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: ties SHALL alternate; the last-granted requester loses the next tie; the starve counter SHALL NOT be built.
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: fixed data priority with the starvation guard of REQ-030/031 SHALL apply.

Verification
REQ-036 IF-only read of addr 0x10 with RAM word 4 = 0xDEADBEEF -> ram_addr=4 at handshake; if_rsp_valid=1, data 0xDEADBEEF exactly 1 cycle later.
REQ-037 Store to 0x20, wstrb=4'b0011, wdata=0x12345678, then load 0x20 over a RAM preset to 0 -> ram_we=0011; d_rsp_data=0 (ack); load returns 0x00005678.
REQ-038 Fixed mode, both valid continuously for 10 cycles -> D granted 4 cycles, IF granted on cycle 5, then pattern repeats.
REQ-039 ARB_ROUND_ROBIN_EN, both valid 6 cycles from reset -> grants IF,D,IF,D,IF,D.
REQ-040 rst asserted one cycle after an IF handshake -> no if_rsp_valid; all outputs 0; normal operation on the first cycle after rst deasserts.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IF and data requesters, the arbiter
// and a single-port word RAM.
interface mem_arbiter_if #(
  parameter int RAM_AW = 12
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [31:0]       if_req_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              d_req_valid;
  logic              d_req_ready;
  logic [31:0]       d_req_addr;
  logic              d_req_we;
  logic [3:0]        d_req_wstrb;
  logic [31:0]       d_req_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_addr, d_req_we,
    input  d_req_wstrb, d_req_wdata,
    input  ram_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_addr, d_req_we,
    output d_req_wstrb, d_req_wdata,
    output ram_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter, one access per cycle.
// Define ARB_ROUND_ROBIN_EN for alternating ties; default is data priority.
module mem_arbiter #(
  parameter int RAM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DLD,
    OWN_DST
  } owner_e;

  owner_e owner_q, owner_d;

  logic if_v;
  logic d_v;
  logic if_win;
  logic gnt_if;
  logic gnt_d;

  assign if_v = bus.if_req_valid & ~rst;
  assign d_v  = bus.d_req_valid & ~rst;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when IF held the port most recently; reset leaves IF favoured
  logic last_if_q, last_if_d;

  assign if_win = ~last_if_q;

  always_comb begin
    last_if_d = last_if_q;
    if (gnt_if) begin
      last_if_d = 1'b1;
    end else if (gnt_d) begin
      last_if_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_if_q <= 1'b0;
    end else begin
      last_if_q <= last_if_d;
    end
  end
`else
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_q, starve_d;

  assign if_win = (starve_q >= STARVE_LIM);

  always_comb begin
    starve_d = 3'd0;
    if (if_v && !gnt_if) begin
      starve_d = (starve_q == 3'd7) ? starve_q : starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  assign gnt_if = if_v & (~d_v | if_win);
  assign gnt_d  = d_v & ~gnt_if;

  assign bus.if_req_ready = gnt_if;
  assign bus.d_req_ready  = gnt_d;

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 4'b0000;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    owner_d       = OWN_NONE;
    if (gnt_if) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.if_req_addr[RAM_AW+1:2];
      owner_d      = OWN_IF;
    end else if (gnt_d) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.d_req_addr[RAM_AW+1:2];
      if (bus.d_req_we) begin
        bus.ram_we    = bus.d_req_wstrb;
        bus.ram_wdata = bus.d_req_wdata;
        owner_d       = OWN_DST;
      end else begin
        owner_d = OWN_DLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // rst also masks a response whose access was accepted just before it
  logic if_rsp;
  logic d_ld_rsp;
  logic d_st_rsp;

  assign if_rsp   = ~rst & (owner_q == OWN_IF);
  assign d_ld_rsp = ~rst & (owner_q == OWN_DLD);
  assign d_st_rsp = ~rst & (owner_q == OWN_DST);

  assign bus.if_rsp_valid = if_rsp;
  assign bus.if_rsp_data  = if_rsp ? bus.ram_rdata : 32'd0;
  assign bus.d_rsp_valid  = d_ld_rsp | d_st_rsp;
  assign bus.d_rsp_data   = d_ld_rsp ? bus.ram_rdata : 32'd0;

  logic unused_addr;
  assign unused_addr = ^{bus.if_req_addr[31:RAM_AW+2],
                         bus.if_req_addr[1:0],
                         bus.d_req_addr[31:RAM_AW+2],
                         bus.d_req_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random
// traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int RAM_AW     = 12;
  localparam int STARVE_MAX = 4;
  localparam int WORDS      = 1 << RAM_AW;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.RAM_AW(RAM_AW)) bus ();

  mem_arbiter #(
    .RAM_AW     (RAM_AW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:WORDS-1];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  // reference model state
  logic [31:0] shadow [0:WORDS-1];
  int          denials;
  bit          last_if;
  int          pend_kind;   // 0 none, 1 IF, 2 load, 3 store
  logic [31:0] pend_data;
  int          last_gnt;    // 0 none, 1 IF, 2 D

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & (WORDS - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit iv, input logic [31:0] ia,
                       input bit dv, input logic [31:0] da, input bit dwe,
                       input logic [3:0] ws, input logic [31:0] wd);
    bit exp_if, exp_d, if_first;
    int w;
    @(negedge clk);
    rst               = r;
    bus.if_req_valid  = iv;
    bus.if_req_addr   = ia;
    bus.d_req_valid   = dv;
    bus.d_req_addr    = da;
    bus.d_req_we      = dwe;
    bus.d_req_wstrb   = ws;
    bus.d_req_wdata   = wd;
    #1;
    exp_if = 1'b0;
    exp_d  = 1'b0;
    if (!r) begin
      if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
        if_first = !last_if;
`else
        if_first = (denials >= STARVE_MAX);
`endif
        exp_if = if_first;
        exp_d  = !if_first;
      end else begin
        exp_if = iv;
        exp_d  = dv;
      end
    end
    chk("if_ready", 32'(bus.if_req_ready), 32'(exp_if));
    chk("d_ready", 32'(bus.d_req_ready), 32'(exp_d));
    chk("ram_en", 32'(bus.ram_en), 32'(exp_if | exp_d));
    chk("ram_we", 32'(bus.ram_we), (exp_d && dwe) ? 32'(ws) : 32'd0);
    if (r) begin
      chk("ram_addr_rst", 32'(bus.ram_addr), 32'd0);
      chk("ram_wdata_rst", bus.ram_wdata, 32'd0);
    end else if (exp_if || exp_d) begin
      chk("ram_addr", 32'(bus.ram_addr), 32'(word_of(exp_if ? ia : da)));
      if (exp_d && dwe) chk("ram_wdata", bus.ram_wdata, wd);
    end
    chk("if_rsp_valid", 32'(bus.if_rsp_valid), 32'(!r && pend_kind == 1));
    chk("d_rsp_valid", 32'(bus.d_rsp_valid), 32'(!r && pend_kind >= 2));
    if (r) begin
      chk("if_rsp_data_rst", bus.if_rsp_data, 32'd0);
      chk("d_rsp_data_rst", bus.d_rsp_data, 32'd0);
    end else if (pend_kind == 1) begin
      chk("if_rsp_data", bus.if_rsp_data, pend_data);
    end else if (pend_kind >= 2) begin
      chk("d_rsp_data", bus.d_rsp_data, pend_data);
    end
    last_gnt = exp_if ? 1 : (exp_d ? 2 : 0);
    if (r) begin
      pend_kind = 0;
      denials   = 0;
      last_if   = 1'b0;
    end else begin
      pend_kind = 0;
      if (exp_if) begin
        pend_kind = 1;
        pend_data = shadow[word_of(ia)];
        last_if   = 1'b1;
      end else if (exp_d) begin
        w = word_of(da);
        if (dwe) begin
          pend_kind = 3;
          pend_data = 32'd0;
          for (int b = 0; b < 4; b++) begin
            if (ws[b]) shadow[w][8*b +: 8] = wd[8*b +: 8];
          end
        end else begin
          pend_kind = 2;
          pend_data = shadow[w];
        end
        last_if = 1'b0;
      end
      denials = (iv && !exp_if) ? denials + 1 : 0;
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    for (int i = 0; i < WORDS; i++) begin
      mem[i]    = 32'd0;
      shadow[i] = 32'd0;
    end
    denials   = 0;
    last_if   = 1'b0;
    pend_kind = 0;
    pend_data = 32'd0;
    last_gnt  = 0;
    rst       = 1'b1;
    bus.if_req_valid = 1'b0;
    bus.if_req_addr  = 32'd0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_addr   = 32'd0;
    bus.d_req_we     = 1'b0;
    bus.d_req_wstrb  = 4'd0;
    bus.d_req_wdata  = 32'd0;

    do_reset();
    do_reset();

    // IF read of word 4
    mem[4]    = 32'hDEADBEEF;
    shadow[4] = 32'hDEADBEEF;
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    chk("req036_addr", 32'(bus.ram_addr), 32'd4);
    idle();
    chk("req036_valid", 32'(bus.if_rsp_valid), 32'd1);
    chk("req036_data", bus.if_rsp_data, 32'hDEADBEEF);

    // partial store then load back
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h20, 1'b1, 4'b0011, 32'h12345678);
    chk("req037_we", 32'(bus.ram_we), 32'h3);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h20, 1'b0, 4'd0, 32'd0);
    chk("req037_ack_valid", 32'(bus.d_rsp_valid), 32'd1);
    chk("req037_ack_data", bus.d_rsp_data, 32'd0);
    idle();
    chk("req037_load", bus.d_rsp_data, 32'h00005678);

    // zero-strobe store still acknowledged
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h24, 1'b1, 4'b0000, 32'hFFFFFFFF);
    idle();
    chk("wstrb0_ack", 32'(bus.d_rsp_valid), 32'd1);

`ifdef ARB_ROUND_ROBIN_EN
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 32'h40 + 32'(4*i), 1'b1, 32'h80 + 32'(4*i),
            1'b0, 4'd0, 32'd0);
      chk("req039_grant", 32'(last_gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
`else
    idle();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 32'h40 + 32'(4*i), 1'b1, 32'h80 + 32'(4*i),
            1'b0, 4'd0, 32'd0);
      chk("req038_grant", 32'(last_gnt), (i % 5 == 4) ? 32'd1 : 32'd2);
    end
`endif

    // reset right after an IF handshake drops its response
    idle();
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1, 4'hF, 32'hA5A5A5A5);
    chk("req040_rsp", 32'(bus.if_rsp_valid), 32'd0);
    chk("req040_ready", 32'({bus.if_req_ready, bus.d_req_ready}), 32'd0);
    chk("req040_en", 32'(bus.ram_en), 32'd0);
    cycle(1'b0, 1'b1, 32'h10, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    chk("req040_resume", 32'(bus.if_req_ready), 32'd1);
    idle();
    chk("req040_data", bus.if_rsp_data, 32'hDEADBEEF);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      ra = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
      rb = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2)
           | 32'($urandom_range(0, 3));
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), ra,
            ($urandom_range(0, 2) != 0), rb, $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), $urandom);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
